// File: rtl/btn_debounce_if.sv
// Button debounce interface: raw line in, qualified level and status out.
// Optional DEBOUNCE_GLITCH_CNT_EN adds the rejected-bounce counter.
interface btn_debounce_if;
  logic       btn_in;
  logic       btn_out;
  logic       busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;

  modport master (output btn_in, input btn_out, input busy, input glitch_cnt);
  modport slave  (input btn_in, output btn_out, output busy, output glitch_cnt);
`else
  modport master (output btn_in, input btn_out, input busy);
  modport slave  (input btn_in, output btn_out, output busy);
`endif
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a raw button line into clk and only lets a new
// level through after it has been stable for STABLE_CYCLES cycles.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN (saturating count of
// rejected bounces on bus.glitch_cnt).
module btn_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic         clk,
  input  logic         rst,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    QUAL_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    QUAL_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   btn_out_q;
  logic                   busy_q;

  // Shift the raw line through the synchroniser; only the last stage is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Qualification FSM; counter restarts on every state change, a revert always
  // beats a same-cycle terminal count, and outputs are registered with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      btn_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE_LOW: begin
          btn_out_q <= 1'b0;
          cnt_q     <= '0;
          if (s) begin
            state_q <= QUAL_HIGH;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        QUAL_HIGH: begin
          if (!s) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE_HIGH;
            cnt_q     <= '0;
            btn_out_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE_HIGH: begin
          btn_out_q <= 1'b1;
          cnt_q     <= '0;
          if (!s) begin
            state_q <= QUAL_LOW;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        QUAL_LOW: begin
          if (s) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE_LOW;
            cnt_q     <= '0;
            btn_out_q <= 1'b0;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE_LOW;
          cnt_q     <= '0;
          btn_out_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.btn_out = btn_out_q;
  assign bus.busy    = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q;
  logic       glitch_evt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign glitch_evt = ((state_q == QUAL_HIGH) && !s) ||
                      ((state_q == QUAL_LOW)  &&  s);

  // Count every aborted qualification, holding at full scale until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             glitch_q <= 8'd0;
    else if (glitch_evt) glitch_q <= sat_inc(glitch_q);
  end

  assign bus.glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with SYNC_STAGES=2, STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so after the k-th tick the outputs reflect edge k.
module tb_btn_debounce;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_chk;
  int   exp_glitch;

  btn_debounce_if ifc ();

  btn_debounce #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic e_out, e_busy;
    rst = 1'b1;
    ifc.btn_in = 1'b1;
    exp_glitch = 0;
    repeat (3) tick();
    n_chk++;
    if (ifc.btn_out !== 1'b0 || ifc.busy !== 1'b0)
      $display("FAIL reset_hold: btn_out=%b busy=%b required 0 0", ifc.btn_out, ifc.busy);
    else n_pass++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'd0)
      $display("FAIL reset_glitch: got %0d required 0", ifc.glitch_cnt);
    else n_pass++;
`endif
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_out  = (k >= 7);
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== e_out || ifc.busy !== e_busy)
        $display("FAIL reset_release edge %0d: btn_out=%b busy=%b required %b %b",
                 k, ifc.btn_out, ifc.busy, e_out, e_busy);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic e_out, e_busy;
    // start from the high level left by the reset test: release first
    ifc.btn_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e_out  = (k < 7);
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== e_out || ifc.busy !== e_busy)
        $display("FAIL release0 edge %0d: btn_out=%b busy=%b required %b %b",
                 k, ifc.btn_out, ifc.busy, e_out, e_busy);
      else n_pass++;
    end
    ifc.btn_in = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e_out  = (k >= 7);
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== e_out || ifc.busy !== e_busy)
        $display("FAIL press edge %0d: btn_out=%b busy=%b required %b %b",
                 k, ifc.btn_out, ifc.busy, e_out, e_busy);
      else n_pass++;
    end
    ifc.btn_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e_out  = (k < 7);
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== e_out || ifc.busy !== e_busy)
        $display("FAIL release edge %0d: btn_out=%b busy=%b required %b %b",
                 k, ifc.btn_out, ifc.busy, e_out, e_busy);
      else n_pass++;
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'(exp_glitch))
      $display("FAIL clean_glitch: got %0d required %0d", ifc.glitch_cnt, exp_glitch);
    else n_pass++;
`endif
  endtask

  task automatic test_bounce();
    logic bpat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 1; k <= 16; k++) begin
      ifc.btn_in = (k <= 8) ? bpat[k-1] : 1'b0;
      tick();
      n_chk++;
      if (ifc.btn_out !== 1'b0)
        $display("FAIL bounce edge %0d: btn_out=%b required 0", k, ifc.btn_out);
      else n_pass++;
    end
    exp_glitch += 2;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'(exp_glitch))
      $display("FAIL bounce_glitch: got %0d required %0d", ifc.glitch_cnt, exp_glitch);
    else n_pass++;
`endif
  endtask

  task automatic test_late_revert();
    logic e_busy;
    for (int k = 1; k <= 12; k++) begin
      ifc.btn_in = (k <= 4);
      tick();
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== 1'b0 || ifc.busy !== e_busy)
        $display("FAIL late_revert edge %0d: btn_out=%b busy=%b required 0 %b",
                 k, ifc.btn_out, ifc.busy, e_busy);
      else n_pass++;
    end
    exp_glitch += 1;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'(exp_glitch))
      $display("FAIL late_glitch: got %0d required %0d", ifc.glitch_cnt, exp_glitch);
    else n_pass++;
`endif
  endtask

  task automatic test_midqual_reset();
    logic e_out, e_busy;
    ifc.btn_in = 1'b1;
    repeat (4) tick();
    n_chk++;
    if (ifc.busy !== 1'b1)
      $display("FAIL midqual_busy: busy=%b required 1", ifc.busy);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    exp_glitch = 0;
    n_chk++;
    if (ifc.busy !== 1'b0 || ifc.btn_out !== 1'b0)
      $display("FAIL midqual_async: btn_out=%b busy=%b required 0 0", ifc.btn_out, ifc.busy);
    else n_pass++;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'd0)
      $display("FAIL midqual_glitch: got %0d required 0", ifc.glitch_cnt);
    else n_pass++;
`endif
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_out  = (k >= 7);
      e_busy = (k >= 3 && k <= 6);
      n_chk++;
      if (ifc.btn_out !== e_out || ifc.busy !== e_busy)
        $display("FAIL midqual_requal edge %0d: btn_out=%b busy=%b required %b %b",
                 k, ifc.btn_out, ifc.busy, e_out, e_busy);
      else n_pass++;
    end
    ifc.btn_in = 1'b0;
    repeat (12) tick();
    n_chk++;
    if (ifc.btn_out !== 1'b0 || ifc.busy !== 1'b0)
      $display("FAIL midqual_settle: btn_out=%b busy=%b required 0 0", ifc.btn_out, ifc.busy);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      ifc.btn_in = 1'b1;
      tick();
      if (ifc.btn_out !== 1'b0) bad++;
      ifc.btn_in = 1'b0;
      tick();
      if (ifc.btn_out !== 1'b0) bad++;
    end
    repeat (4) tick();
    n_chk++;
    if (bad != 0 || ifc.btn_out !== 1'b0)
      $display("FAIL sat_btn_out: %0d high samples, final btn_out=%b required 0", bad, ifc.btn_out);
    else n_pass++;
    exp_glitch = (exp_glitch + 300 > 255) ? 255 : exp_glitch + 300;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_chk++;
    if (ifc.glitch_cnt !== 8'(exp_glitch))
      $display("FAIL sat_glitch: got %0d required %0d", ifc.glitch_cnt, exp_glitch);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    rst = 1'b1;
    ifc.btn_in = 1'b0;
    tick();
    test_reset();
    test_clean_press();
    test_bounce();
    test_late_revert();
    test_midqual_reset();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
